alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle ALU: the RV32I/RV64I integer ops plus the M-extension multiply/divide ops.
- Sits in the execute stage. A valid/ready handshake lets the pipeline stall on multi-cycle ops.
- Base ops complete in 1 cycle. MUL*/DIV*/REM* run iteratively, one bit per cycle.
- Combinational compare flags for branch resolution stay available every cycle.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- SHAMT_W, $clog2(XLEN), number of shift-amount bits taken from op_b.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  6  {funct7[0], opcode[5], funct7[5], funct3[2:0]}.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value or immediate.
- flush  in  1  synchronous abort of any op in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- eq_flag  out  1  combinational: op_a == op_b.
- lt_flag  out  1  combinational: signed op_a < op_b.
- ltu_flag  out  1  combinational: unsigned op_a < op_b.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, internal counters/accumulators=0. in_ready=1 once reset deasserts.
- Decode, op[5]=0 (base ops, same table as the single-cycle ALU):
  - 0x000 → ADDI (add); 10000 → ADD; 11000 → SUB.
  - xx111 → AND; xx110 → OR; xx100 → XOR.
  - x0001 → SLL; x0101 → SRL; x1101 → SRA. Shift amount is op_b[SHAMT_W-1:0].
  - xx010 → SLT; xx011 → SLTU. Both produce a 0/1 result, zero-extended.
  - Any other op → result 0.
- Decode, op[5]=1 (M ops, valid only when op[4]=1; otherwise treated as base ops), by funct3:
  - 000 MUL (low XLEN); 001 MULH (s×s high); 010 MULHSU (s×u high); 011 MULHU (u×u high).
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- Handshake: a transfer occurs when in_valid && in_ready. Operands are latched; op_a/op_b may change afterwards.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE → DONE on accept of a base op or an M special case. result is written in the same edge.
  - IDLE → CALC on accept of a normal M op. Operands are converted to magnitudes; negate flags are recorded.
  - CALC runs exactly XLEN cycles. Counter counts XLEN-1 down to 0.
    - Multiply: shift-add into a 2·XLEN accumulator.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
  - CALC → FIX when counter = 0. FIX applies sign correction, selects the high or low half (mul) or quotient/remainder (div), and writes result.
  - FIX → DONE.
  - DONE holds out_valid=1 with result stable until out_ready=1, then → IDLE.
- Latency from accept edge to out_valid=1:
  - Base ops and special cases: 1 cycle.
  - M ops: XLEN+2 cycles.
- No new accept while in DONE; back-to-back throughput is 1 op per 2 cycles for base ops.
- Special cases (no CALC):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (op_a = MIN, op_b = −1): DIV → MIN; REM → 0.
  - Multiply by zero still runs the full CALC (fixed latency).
- Signs:
  - Quotient is negative iff operand signs differ (and divisor ≠ 0).
  - Remainder takes the dividend's sign.
  - MULHSU treats only op_a as signed.
- flush=1: next edge → IDLE, out_valid=0, in-flight op discarded, result unchanged. flush takes priority over accept and over out handshake in the same cycle.
- Reset mid-operation: immediate return to reset values; no partial result is visible.
- Flags are purely combinational on the current op_a/op_b, independent of state.

Test Plan:
- Base ops, XLEN=32, out_ready=1:
  - ADD 7+5 → result=12, out_valid exactly 1 cycle after accept.
  - SUB 3−5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLT −1<1 → 1; SLTU −1<1 → 0.
- Multiply:
  - MUL 0xFFFFFFFF×2 → 0xFFFFFFFE.
  - MULH −2×3 → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - out_valid exactly 34 cycles after accept; in_ready=0 throughout.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM → 0.
  - All special cases: latency 1.
- Backpressure and flush:
  - out_ready=0 for 5 cycles: result stable, out_valid held, in_ready=0; completes on out_ready.
  - flush at CALC cycle 10 → IDLE next cycle, no out_valid.
  - rst_n pulsed low mid-CALC → all outputs 0 asynchronously.
- XLEN=64 build: MULHU (2^64−1)² → 0xFFFFFFFFFFFFFFFE, latency 66; SLL by op_b=65 uses shamt 1.

Source files
------------

// File: rtl/alu_mdu.sv
// Execute-stage integer ALU with iterative RV M-extension multiply/divide.
// Base ops finish in one cycle; MUL*/DIV*/REM* take one bit per cycle over XLEN cycles.
module alu_mdu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            eq_flag,
    output logic            lt_flag,
    output logic            ltu_flag
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    logic [2*XLEN-1:0]   acc, acc_nxt;
    logic [XLEN-1:0]     opnd;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          func;
    logic                neg;

    logic                is_m, sgn_a, sgn_b, neg_a, neg_b, special;
    logic [XLEN-1:0]     mag_a, mag_b, spec_res, base_res, q_s, r_s, fix_res;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN:0]       sum, diff;
    logic [2*XLEN-1:0]   prod;

    assign eq_flag  = (op_a == op_b);
    assign lt_flag  = ($signed(op_a) < $signed(op_b));
    assign ltu_flag = (op_a < op_b);
    assign in_ready = rst_n && (state == IDLE);

    // M-op decode: signedness per operand, magnitudes and the divide special cases
    always_comb begin
        is_m     = op[5] & op[4];
        sgn_a    = op[2] ? ~op[0] : (op[1] ^ op[0]);
        sgn_b    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        neg_a    = sgn_a & op_a[XLEN-1];
        neg_b    = sgn_b & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        special  = op[2] && (op_b == '0 || (sgn_a && op_a == MIN && op_b == '1));
        spec_res = '0;
        if (op_b == '0) spec_res = op[1] ? op_a : '1;
        else            spec_res = op[1] ? '0 : MIN;
    end

    always_comb begin
        shamt    = op_b[SHAMT_W-1:0];
        base_res = '0;
        case (op[2:0])
            3'b000: begin
                if (op[4] && op[3]) base_res = op_a - op_b;
                else                base_res = op_a + op_b;
            end
            3'b001: if (!op[3]) base_res = op_a << shamt;
            3'b101: begin
                if (op[3]) base_res = $signed(op_a) >>> shamt;
                else       base_res = op_a >> shamt;
            end
            3'b010: base_res = {{(XLEN-1){1'b0}}, lt_flag};
            3'b011: base_res = {{(XLEN-1){1'b0}}, ltu_flag};
            3'b100: base_res = op_a ^ op_b;
            3'b110: base_res = op_a | op_b;
            default: base_res = op_a & op_b;
        endcase
    end

    // One iteration: acc = {hi, lo}. Multiply shifts right adding into hi;
    // divide shifts left, trial-subtracting the divisor from the partial remainder.
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        diff = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
        if (!func[2])           acc_nxt = {sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])   acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else                    acc_nxt = {acc[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod = neg ? -acc : acc;
        q_s  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_s  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (func[2])               fix_res = func[1] ? r_s : q_s;
        else if (func[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
        else                       fix_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            func      <= '0;
            neg       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (!is_m || special) begin
                        result    <= is_m ? spec_res : base_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, mag_a};
                        opnd  <= mag_b;
                        cnt   <= CNT_W'(XLEN - 1);
                        func  <= op[2:0];
                        // remainder follows the dividend; everything else the xor of signs
                        neg   <= (op[2] && op[1]) ? neg_a : (neg_a ^ neg_b);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    result    <= fix_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: wide-integer reference model, per-cycle monitor, directed and random ops.
module tb_alu_mdu;
    localparam int X = 32;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic in_valid = 0, flush = 0, out_ready = 1;
    logic [5:0] op = 0;
    logic [X-1:0] op_a = 0, op_b = 0;
    logic in_ready, out_valid, eq_flag, lt_flag, ltu_flag;
    logic [X-1:0] result;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .op_a(op_a), .op_b(op_b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .eq_flag(eq_flag), .lt_flag(lt_flag), .ltu_flag(ltu_flag));

    logic iv64 = 0, ir64, ov64, e64, l64, lu64;
    logic [5:0] op64 = 0;
    logic [63:0] a64 = 0, b64 = 0, r64;

    alu_mdu #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .op(op64),
        .op_a(a64), .op_b(b64), .flush(flush), .out_valid(ov64), .out_ready(1'b1),
        .result(r64), .eq_flag(e64), .lt_flag(l64), .ltu_flag(lu64));

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic shown = 0;
    logic [31:0] last_res = 0;
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, pu;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        sh = int'(b[4:0]);
        if (o[5] && o[4]) begin
            case (o[2:0])
                3'd0: begin pu = ua * ub; return pu[31:0]; end
                3'd1: begin p = sa * sb; return p[63:32]; end
                3'd2: begin p = sa * longint'(ub); return p[63:32]; end
                3'd3: begin pu = ua * ub; return pu[63:32]; end
                3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
                3'd5: begin if (b == 0) return '1; pu = ua / ub; return pu[31:0]; end
                3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
                default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
            endcase
        end
        if (o[2:0] == 3'b000) return (o[4] && o[3]) ? a - b : a + b;
        if (o[2:0] == 3'b111) return a & b;
        if (o[2:0] == 3'b110) return a | b;
        if (o[2:0] == 3'b100) return a ^ b;
        if (o[2:0] == 3'b010) return (sa < sb) ? 32'd1 : 32'd0;
        if (o[2:0] == 3'b011) return (ua < ub) ? 32'd1 : 32'd0;
        if (o[2:0] == 3'b001) return o[3] ? 32'd0 : a << sh;
        if (o[3]) begin p = sa >>> sh; return p[31:0]; end
        return a >> sh;
    endfunction

    function automatic int mlat(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!(o[5] && o[4])) return 1;
        if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return X + 2;
    endfunction

    // Per-cycle monitor: flags, in_ready, result/latency of each completed op, hold stability
    always @(negedge clk) begin
        if (rst_n) begin
            chk("eq_flag", eq_flag, op_a == op_b);
            chk("lt_flag", lt_flag, $signed(op_a) < $signed(op_b));
            chk("ltu_flag", ltu_flag, op_a < op_b);
            chk("in_ready", in_ready, q.size() == 0 && !out_valid);
            if (out_valid) begin
                if (!shown) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out_valid: got result %0h with no op pending", result);
                        cur.res = result;
                    end else begin
                        cur = q.pop_front();
                        chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
                    end
                    shown = 1;
                end
                chk("result", result, cur.res);
                if (out_ready) begin
                    shown = 0;
                    last_res = result;
                    done_cnt++;
                end
            end
        end
    end

    // mode 0: out_ready always 1; 1: random; 2: held low for 5 valid cycles
    task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input bit lit_en, input logic [31:0] lit, input string nm);
        int d0, n, vcnt;
        exp_t e;
        d0 = done_cnt;
        op = o; op_a = a; op_b = b; in_valid = 1;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        e.res = model(o, a, b); e.lat = mlat(o, a, b); e.acc = cyc;
        q.push_back(e);
        in_valid = 0; op_a = $urandom; op_b = $urandom; op = 6'($urandom);
        n = 0; vcnt = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            if (out_valid) vcnt++;
            @(posedge clk); #1;
            n++;
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) out_ready = (vcnt >= 5);
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got no completion expected one within 200 cycles", nm);
            q.delete(); shown = 0;
        end
        out_ready = 1;
        if (lit_en) chk(nm, last_res, lit);
    endtask

    task automatic run64(input logic [5:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] lit, input int lat, input string nm);
        int n;
        op64 = o; a64 = a; b64 = b; iv64 = 1;
        #1 chk({nm, "_eq"}, e64, a == b);
        chk({nm, "_lt"}, l64, $signed(a) < $signed(b));
        chk({nm, "_ltu"}, lu64, a < b);
        @(posedge clk); #1;
        iv64 = 0; n = 1;
        while (!ov64 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_res"}, r64, lit);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        exp_t e;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("in_ready64_after_reset", ir64, 1);
        @(posedge clk); #1;

        run(6'b010000, 7, 5, 0, 1, 12, "add");
        run(6'b011000, 3, 5, 0, 1, 32'hFFFF_FFFE, "sub");
        run(6'b011101, 32'h8000_0000, 4, 0, 1, 32'hF800_0000, "sra");
        run(6'b010010, 32'hFFFF_FFFF, 1, 0, 1, 1, "slt");
        run(6'b010011, 32'hFFFF_FFFF, 1, 0, 1, 0, "sltu");
        run(6'b001000, 1, 2, 0, 1, 3, "addi");
        run(6'b011001, 5, 1, 0, 1, 0, "undef_base");
        run(6'b100111, 32'hF0F0, 32'hFF00, 0, 1, 32'hF000, "and_op5_noM");
        run(6'b110000, 32'hFFFF_FFFF, 2, 0, 1, 32'hFFFF_FFFE, "mul");
        run(6'b110001, 32'hFFFF_FFFE, 3, 0, 1, 32'hFFFF_FFFF, "mulh");
        run(6'b110011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, "mulhu");
        run(6'b110010, 32'hFFFF_FFFE, 3, 0, 1, 32'hFFFF_FFFF, "mulhsu");
        run(6'b110100, 32'hFFFF_FFF9, 2, 0, 1, 32'hFFFF_FFFD, "div");
        run(6'b110110, 32'hFFFF_FFF9, 2, 0, 1, 32'hFFFF_FFFF, "rem");
        run(6'b110101, 100, 7, 0, 1, 14, "divu");
        run(6'b110111, 100, 7, 0, 1, 2, "remu");
        run(6'b110100, 5, 0, 0, 1, 32'hFFFF_FFFF, "div_by_zero");
        run(6'b110111, 5, 0, 0, 1, 5, "remu_by_zero");
        run(6'b110100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, "div_ovf");
        run(6'b110110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, "rem_ovf");
        run(6'b110101, 100, 7, 2, 1, 14, "divu_backpressure");
        run(6'b010000, 9, 9, 2, 1, 18, "add_backpressure");

        // flush mid-CALC: op dropped, result untouched, no out_valid afterwards
        prev = result;
        op = 6'b110011; op_a = 32'hFFFF_FFFF; op_b = 3; in_valid = 1;
        @(posedge clk); #1;
        e.res = 0; e.lat = 0; e.acc = cyc; q.push_back(e);
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk); #1;
        flush = 0; q.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_result", result, prev);
        repeat (40) @(posedge clk);
        #1;
        // flush wins over a same-cycle accept
        op = 6'b010000; op_a = 1; op_b = 1; in_valid = 1; flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        chk("flush_vs_accept", out_valid, 0);

        // async reset mid-CALC
        run(6'b010000, 7, 5, 0, 1, 12, "add_pre_reset");
        op = 6'b110000; op_a = 123; op_b = 456; in_valid = 1;
        @(posedge clk); #1;
        e.res = 0; e.lat = 0; e.acc = cyc; q.push_back(e);
        in_valid = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midreset_result", result, 0);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 0);
        q.delete(); shown = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 250; i++)
            run(6'($urandom_range(0, 63)), rnd_val(), rnd_val(), int'($urandom_range(0, 1)), 0, 0, "rand");

        run64(6'b110011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu64");
        run64(6'b010001, 64'h1, 64'd65, 64'h2, 1, "sll64");
        run64(6'b110100, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div64");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test expected finish before 900000ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule
